// File: rtl/mul_pkg.sv
// Shared widths, latency and result record for the multiplier stream stage.
package mul_pkg;

  localparam int OPERAND_W     = 64;
  localparam int PRODUCT_W     = 128;
  // Pipeline depth of the 64x64 multiplier: one product register plus six
  // adder-tree levels. The multiplier's sum tree is built from this value too.
  localparam int MUL_LATENCY   = 7;
  localparam int TAG_W_DEFAULT = 8;

  typedef struct packed {
    logic [PRODUCT_W-1:0]     product;
    logic [TAG_W_DEFAULT-1:0] tag;
  } mul_result_t;

  // Pointer width for a circular buffer of 'depth' entries, never below 1 bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// First-word-fall-through result FIFO. The head entry is visible whenever the
// FIFO is not empty and reads as zero when it is empty. DEPTH does not need
// to be a power of two because both pointers wrap explicitly.
module result_fifo
  import mul_pkg::*;
#(
  parameter int  DEPTH   = 16,
  parameter type entry_t = mul_result_t
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  entry_t                       push_data,
  input  logic                         pop,
  output entry_t                       head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int                PTR_W    = ptr_w(DEPTH);
  localparam int                CNT_W    = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop frees the head slot in the same edge, so push-on-full is allowed
  // only when it is paired with a pop.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = empty ? '0 : mem[rd_ptr];

  // Storage array: written on push, no reset needed since head is masked when empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping with explicit modulo-DEPTH wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // The upstream credit scheme must never present a push that would be lost.
  push_into_full_fifo: assert property (
    @(posedge clk) disable iff (rst) !(push && full && !pop)
  );

endmodule

// File: rtl/mul_stream_ctrl.sv
// Valid/ready issue-and-collect stage around the fixed-latency pipelined
// multiplier. Operands are registered onto the multiplier, a valid/tag pipe
// follows each operation, and products land in a result FIFO. Admission is
// credit based: occ counts in-flight plus stored results, so the stall-free
// multiplier can never overrun the FIFO.
module mul_stream_ctrl
  import mul_pkg::*;
#(
  parameter int LATENCY = MUL_LATENCY,
  parameter int DEPTH   = 16,
  parameter int TAG_W   = TAG_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPERAND_W-1:0] in_a,
  input  logic [OPERAND_W-1:0] in_b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic [OPERAND_W-1:0] mul_a,
  output logic [OPERAND_W-1:0] mul_b,
  input  logic [PRODUCT_W-1:0] mul_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PRODUCT_W-1:0] out_data,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 busy
);

  localparam int               OCC_W     = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

  // Result record sized by this instance's TAG_W.
  typedef struct packed {
    logic [PRODUCT_W-1:0] product;
    logic [TAG_W-1:0]     tag;
  } result_t;

  logic [OCC_W-1:0] occ;
  logic [LATENCY:0] v;
  logic [TAG_W-1:0] t [LATENCY+1];
  logic             accept;
  logic             pop;
  result_t          push_entry;
  result_t          head_entry;
  logic             fifo_full;
  logic             fifo_empty;
  logic [OCC_W-1:0] fifo_count;

  // in_ready comes from registered occ only, never from out_ready.
  assign in_ready = ~rst & (occ < DEPTH_OCC);
  assign accept   = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  assign busy     = (occ != '0);

  assign push_entry = '{product: mul_out, tag: t[LATENCY]};
  assign out_valid  = ~fifo_empty;
  assign out_data   = head_entry.product;
  assign out_tag    = head_entry.tag;

  // Operand registers feeding the multiplier; they hold between accepts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a <= '0;
      mul_b <= '0;
    end else if (accept) begin
      mul_a <= in_a;
      mul_b <= in_b;
    end
  end

  // Valid/tag shift pipe: stage LATENCY lines up with the product on mul_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      for (int k = 0; k <= LATENCY; k++) begin
        t[k] <= '0;
      end
    end else begin
      v <= {v[LATENCY-1:0], accept};
      if (accept) begin
        t[0] <= in_tag;
      end
      for (int k = 1; k <= LATENCY; k++) begin
        t[k] <= t[k-1];
      end
    end
  end

  // Credit counter: one credit taken on accept, returned on pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  result_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (result_t)
  ) u_result_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (v[LATENCY]),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Stored results are a subset of the credits handed out, and a capture
  // must never meet a full FIFO.
  credits_cover_fifo: assert property (
    @(posedge clk) disable iff (rst) fifo_count <= occ
  );
  no_capture_when_full: assert property (
    @(posedge clk) disable iff (rst) !(v[LATENCY] && fifo_full)
  );

endmodule

// File: tb/tb_mul_stream_ctrl.sv
// Self-checking bench for mul_stream_ctrl. A behavioural multiplier delays
// mul_a*mul_b by LAT edges, and a queue-based reference model predicts every
// output after each clock edge.
module tb_mul_stream_ctrl;

  localparam int LAT   = 7;
  localparam int DEPTH = 16;
  localparam int TW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [63:0]   in_a = '0;
  logic [63:0]   in_b = '0;
  logic [TW-1:0] in_tag = '0;
  logic [63:0]   mul_a;
  logic [63:0]   mul_b;
  logic [127:0]  mul_out;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [127:0]  out_data;
  logic [TW-1:0] out_tag;
  logic          busy;

  int errors = 0;
  int checks = 0;

  // 10 ns clock
  always #5 clk = ~clk;

  mul_stream_ctrl #(
    .LATENCY (LAT),
    .DEPTH   (DEPTH),
    .TAG_W   (TW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_out   (mul_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  // Behavioural multiplier: the product of the registered operands appears
  // on mul_out LAT edges after they were loaded.
  logic [127:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= {64'b0, mul_a} * {64'b0, mul_b};
    for (int k = 1; k < LAT; k++) begin
      mpipe[k] <= mpipe[k-1];
    end
  end
  assign mul_out = mpipe[LAT-1];

  // Reference model: accepted operations wait in flight_q until their due
  // edge, then join fifo_q; m_occ counts every credit handed out.
  typedef struct {
    logic [127:0]  prod;
    logic [TW-1:0] tag;
    int            due;
  } op_t;

  op_t flight_q [$];
  op_t fifo_q   [$];
  int  m_occ  = 0;
  int  edge_n = 0;

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Compare every DUT output against what the model predicts right now.
  task automatic checkAll();
    logic [127:0] exp_data;
    logic [TW-1:0] exp_tag;
    exp_data = '0;
    exp_tag  = '0;
    if (fifo_q.size() != 0) begin
      exp_data = fifo_q[0].prod;
      exp_tag  = fifo_q[0].tag;
    end
    checkOutput("in_ready",  in_ready,  (m_occ < DEPTH) && !rst);
    checkOutput("out_valid", out_valid, fifo_q.size() != 0);
    checkOutput("out_data",  out_data,  exp_data);
    checkOutput("out_tag",   out_tag,   exp_tag);
    checkOutput("busy",      busy,      m_occ != 0);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then
  // check outputs on the falling edge.
  task automatic applyStimulus(input logic iv, input logic [63:0] a, input logic [63:0] b,
                               input logic [TW-1:0] tg, input logic ordy);
    bit  acc;
    bit  pp;
    op_t op;
    in_valid  = iv;
    in_a      = a;
    in_b      = b;
    in_tag    = tg;
    out_ready = ordy;
    acc = iv && (m_occ < DEPTH);
    pp  = ordy && (fifo_q.size() != 0);
    @(posedge clk);
    edge_n++;
    if (pp) begin
      void'(fifo_q.pop_front());
    end
    while (flight_q.size() != 0 && flight_q[0].due == edge_n) begin
      fifo_q.push_back(flight_q.pop_front());
    end
    if (acc) begin
      op.prod = {64'b0, a} * {64'b0, b};
      op.tag  = tg;
      op.due  = edge_n + LAT + 1;
      flight_q.push_back(op);
    end
    m_occ = m_occ + (acc ? 1 : 0) - (pp ? 1 : 0);
    @(negedge clk);
    checkAll();
  endtask

  // Asynchronous reset held across n rising edges; the model forgets everything.
  task automatic doReset(input int n);
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flight_q.delete();
    fifo_q.delete();
    m_occ = 0;
    #1;
    checkAll();
    repeat (n) @(posedge clk);
    @(negedge clk);
    checkAll();
    rst = 1'b0;
    #1;
    checkAll();
  endtask

  // Idle with out_ready low until a result shows up; lat is edges since the accept.
  task automatic waitResult(output int lat);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      applyStimulus(1'b0, '0, '0, '0, 1'b0);
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // Hard stop in case something hangs.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by a randomized soak.
  initial begin
    int lat;
    int cnt;
    int pops;
    int stalls;
    int idx;
    bit ready_now;
    bit valid_now;

    #2;
    doReset(2);

    // Single small operation, latency and busy return
    applyStimulus(1'b1, 64'd3, 64'd5, 8'h11, 1'b0);
    waitResult(lat);
    checkOutput("t1_latency", lat, 8);
    checkOutput("t1_data", out_data, 128'd15);
    checkOutput("t1_tag", out_tag, 8'h11);
    applyStimulus(1'b0, '0, '0, '0, 1'b1);
    checkOutput("t1_busy_after_pop", busy, 1'b0);

    // Largest operands
    applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'h22, 1'b0);
    waitResult(lat);
    checkOutput("t2_latency", lat, 8);
    checkOutput("t2_data", out_data, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    applyStimulus(1'b0, '0, '0, '0, 1'b1);

    // 100 back-to-back operations with downstream always ready
    idx = 0; stalls = 0; pops = 0;
    while (idx < 100) begin
      ready_now = in_ready;
      valid_now = out_valid;
      applyStimulus(1'b1, rand64(), rand64(), idx[TW-1:0], 1'b1);
      if (ready_now) idx++; else stalls++;
      if (valid_now) pops++;
      if (stalls > 50) break;
    end
    repeat (9) begin
      valid_now = out_valid;
      applyStimulus(1'b0, '0, '0, '0, 1'b1);
      if (valid_now) pops++;
    end
    checkOutput("t3_stalls", stalls, 0);
    checkOutput("t3_pops", pops, 100);
    checkOutput("t3_idle", busy, 1'b0);

    // Backpressure: exactly DEPTH accepts, then drain in order
    cnt = 0; idx = 0;
    repeat (30) begin
      if (in_ready) cnt++;
      applyStimulus(1'b1, rand64(), rand64(), idx[TW-1:0], 1'b0);
      idx = cnt;
    end
    checkOutput("t4_accepts", cnt, DEPTH);
    checkOutput("t4_ready_low", in_ready, 1'b0);
    applyStimulus(1'b0, '0, '0, '0, 1'b1);
    checkOutput("t4_ready_after_pop", in_ready, 1'b1);
    pops = 1;
    repeat (20) begin
      valid_now = out_valid;
      applyStimulus(1'b0, '0, '0, '0, 1'b1);
      if (valid_now) pops++;
    end
    checkOutput("t4_drained", pops, DEPTH);
    checkOutput("t4_idle", busy, 1'b0);

    // Full stage: one pop pulse lets exactly one more op in
    repeat (30) applyStimulus(1'b1, rand64(), rand64(), 8'h40, 1'b0);
    checkOutput("t5_full_ready", in_ready, 1'b0);
    applyStimulus(1'b1, rand64(), rand64(), 8'h41, 1'b1);
    checkOutput("t5_ready_reopened", in_ready, 1'b1);
    applyStimulus(1'b1, rand64(), rand64(), 8'h42, 1'b0);
    checkOutput("t5_ready_closed", in_ready, 1'b0);
    repeat (10) applyStimulus(1'b0, '0, '0, '0, 1'b0);
    checkOutput("t5_still_full", out_valid, 1'b1);
    repeat (20) applyStimulus(1'b0, '0, '0, '0, 1'b1);
    checkOutput("t5_idle", busy, 1'b0);

    // Reset in the middle of a burst discards everything
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, rand64(), rand64(), TW'(k + 8'h60), 1'b1);
    end
    repeat (3) applyStimulus(1'b0, '0, '0, '0, 1'b1);
    doReset(2);
    cnt = 0;
    repeat (20) begin
      applyStimulus(1'b0, '0, '0, '0, 1'b1);
      if (out_valid) cnt++;
    end
    checkOutput("t6_spurious", cnt, 0);
    applyStimulus(1'b1, 64'd7, 64'd6, 8'h77, 1'b0);
    waitResult(lat);
    checkOutput("t6_latency", lat, 8);
    checkOutput("t6_data", out_data, 128'd42);
    applyStimulus(1'b0, '0, '0, '0, 1'b1);

    // Randomized soak against the model
    for (int k = 0; k < 300; k++) begin
      applyStimulus($urandom_range(3) != 0, rand64(), rand64(), TW'($urandom()),
                    $urandom_range(4) > 1);
    end
    repeat (40) applyStimulus(1'b0, '0, '0, '0, 1'b1);
    checkOutput("soak_idle", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
